// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: crops the camera pixel stream to a window and feeds it to the frame-buffer writer.
// Optional build macro CAPTURE_DECIMATE_EN keeps only even col/row offsets inside the window.
module camera_capture_ctrl #(
   parameter int X_START = 0,
   parameter int Y_START = 0,
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int ADDR_W  = 19
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              continuous,
   input  logic              stop,
   input  logic              frame_valid,
   input  logic              line_valid,
   input  logic              pix_valid,
   input  logic [9:0]        pix_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [9:0]        out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow,
   output logic [7:0]        frame_count
);

   localparam int DATA_W = 10;
   localparam int CNT_W  = 12;
   localparam int DEPTH  = 4;

   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, ACTIVE = 2'd2} state_t;
   state_t state_q, state_d;

   logic              fv_q, lv_q, cont_q;
   logic              fv_rise, fv_fall, lv_fall, pix_hit, in_win, keep, capture, idle_start;
   logic [CNT_W-1:0]  col, row;
   logic [ADDR_W-1:0] addr;

   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic [ADDR_W-1:0] addr_p1;

   logic [DATA_W-1:0] buf_data [DEPTH];
   logic [ADDR_W-1:0] buf_addr [DEPTH];
   logic [1:0]        wr_ptr, rd_ptr;
   logic [2:0]        count;
   logic              pop, push, drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign fv_rise    = frame_valid & ~fv_q;
   assign fv_fall    = ~frame_valid & fv_q;
   assign lv_fall    = ~line_valid & lv_q;
   assign pix_hit    = pix_valid & line_valid;
   assign idle_start = (state_q == IDLE) & start;

   assign in_win = (int'(col) >= X_START) && (int'(col) < X_START + WIDTH) &&
                   (int'(row) >= Y_START) && (int'(row) < Y_START + HEIGHT);

`ifdef CAPTURE_DECIMATE_EN
   localparam logic X_LSB = 1'(X_START);
   localparam logic Y_LSB = 1'(Y_START);
   // An even offset from the window origin has the same LSB as the origin.
   assign keep = in_win & (col[0] == X_LSB) & (row[0] == Y_LSB);
`else
   assign keep = in_win;
`endif

   assign capture = (state_q == ACTIVE) & pix_hit & keep;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ARM;
         ARM:     if (stop) state_d = IDLE;
                  else if (fv_rise) state_d = ACTIVE;
         ACTIVE:  if (fv_fall) state_d = (cont_q & ~stop) ? ARM : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         fv_q        <= 1'b0;
         lv_q        <= 1'b0;
         cont_q      <= 1'b0;
         col         <= '0;
         row         <= '0;
         addr        <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
         vld_p1      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fv_q       <= frame_valid;
         lv_q       <= line_valid;
         frame_done <= (state_q == ACTIVE) & fv_fall;
         vld_p1     <= capture;

         if (idle_start) cont_q <= continuous & ~stop;
         else if (stop)  cont_q <= 1'b0;

         if (idle_start) frame_count <= '0;
         else if ((state_q == ACTIVE) && fv_fall) frame_count <= frame_count + 8'd1;

         if (drop) overflow <= 1'b1;
         else if (idle_start) overflow <= 1'b0;

         if ((state_q == ARM) && fv_rise) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
         end else if (state_q == ACTIVE) begin
            if (lv_fall) begin
               col <= '0;
               row <= sat_inc(row);
            end else if (pix_hit) begin
               col <= sat_inc(col);
            end
            // Dropped pixels still consume an address so later words land correctly.
            if (capture) addr <= addr + ADDR_W'(1);
         end
      end
   end

   // p0 -> p1: captured pixel and its address
   always_ff @(posedge clk) begin
      if (capture) begin
         data_p1 <= pix_data;
         addr_p1 <= addr;
      end
   end

   // p1 -> elastic buffer; a pop frees the slot a full-buffer push needs
   assign out_valid = (count != 3'd0);
   assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
   assign out_addr  = out_valid ? buf_addr[rd_ptr] : '0;
   assign pop       = out_valid & out_ready;
   assign push      = vld_p1 & ((count != 3'(DEPTH)) | pop);
   assign drop      = vld_p1 & ~push;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= data_p1;
         buf_addr[wr_ptr] <= addr_p1;
      end
   end

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Bench for camera_capture_ctrl: queue-based reference model checked every cycle, plus fixed scenarios.
module tb_camera_capture_ctrl;

   localparam int XS = 1;
   localparam int YS = 0;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 19;
   localparam int S_IDLE = 0;
   localparam int S_ARM  = 1;
   localparam int S_ACT  = 2;

   typedef struct packed {
      logic [9:0]    d;
      logic [AW-1:0] a;
   } word_t;

   logic          clk = 1'b0;
   logic          reset_n, start, continuous, stop;
   logic          frame_valid, line_valid, pix_valid, out_ready;
   logic [9:0]    pix_data;
   logic          out_valid, busy, frame_done, overflow;
   logic [9:0]    out_data;
   logic [AW-1:0] out_addr;
   logic [7:0]    frame_count;

   camera_capture_ctrl #(.X_START(XS), .Y_START(YS), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous), .stop(stop),
      .frame_valid(frame_valid), .line_valid(line_valid), .pix_valid(pix_valid),
      .pix_data(pix_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .busy(busy), .frame_done(frame_done), .overflow(overflow),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int    n_pass = 0, n_total = 0, n_done = 0;
   bit    chk_en = 0, rnd_ready = 0;
   word_t xlog[$];

   // reference model state
   int    m_st, m_col, m_row, m_addr, m_cnt;
   bit    m_cont, m_fvp, m_lvp, m_ovf, m_done, m_pv;
   word_t m_pw;
   word_t m_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic bit kept(input int c, input int r);
      bit k;
      k = (c >= XS) && (c < XS + W) && (r >= YS) && (r < YS + H);
`ifdef CAPTURE_DECIMATE_EN
      k = k && ((c - XS) % 2 == 0) && ((r - YS) % 2 == 0);
`endif
      return k;
   endfunction

   task automatic model_reset();
      m_st = S_IDLE; m_col = 0; m_row = 0; m_addr = 0; m_cnt = 0;
      m_cont = 0; m_fvp = 0; m_lvp = 0; m_ovf = 0; m_done = 0; m_pv = 0;
      m_q.delete();
   endtask

   task automatic model_step();
      bit fv_rise, fv_fall, lv_fall, hit;
      if (!reset_n) begin
         model_reset();
         return;
      end
      fv_rise = frame_valid && !m_fvp;
      fv_fall = !frame_valid && m_fvp;
      lv_fall = !line_valid && m_lvp;
      hit     = pix_valid && line_valid;
      m_done  = 0;
      if (m_st == S_IDLE && start) begin
         m_ovf = 0;
         m_cnt = 0;
      end
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_pv) begin
         if (m_q.size() < 4) m_q.push_back(m_pw);
         else m_ovf = 1;
      end
      m_pv = 0;
      case (m_st)
         S_IDLE: begin
            if (start) begin
               m_st = S_ARM;
               m_cont = continuous && !stop;
            end else if (stop) m_cont = 0;
         end
         S_ARM: begin
            if (stop) begin
               m_cont = 0;
               m_st = S_IDLE;
            end else if (fv_rise) begin
               m_col = 0; m_row = 0; m_addr = 0; m_st = S_ACT;
            end
         end
         default: begin
            if (stop) m_cont = 0;
            if (hit && kept(m_col, m_row)) begin
               m_pv = 1;
               m_pw.d = pix_data;
               m_pw.a = AW'(m_addr);
               m_addr++;
            end
            if (lv_fall) begin
               m_col = 0;
               m_row = (m_row < 4095) ? m_row + 1 : 4095;
            end else if (hit) m_col++;
            if (fv_fall) begin
               m_done = 1;
               m_cnt = (m_cnt + 1) % 256;
               m_st = m_cont ? S_ARM : S_IDLE;
            end
         end
      endcase
      m_fvp = frame_valid;
      m_lvp = line_valid;
   endtask

   always @(negedge clk) begin
      word_t w;
      if (chk_en) begin
         check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(m_q[0].d));
            check("out_addr", 32'(out_addr), 32'(m_q[0].a));
         end
         check("busy", 32'(busy), 32'(m_st != S_IDLE));
         check("frame_done", 32'(frame_done), 32'(m_done));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("frame_count", 32'(frame_count), 32'(m_cnt));
         if (out_valid && out_ready) begin
            w.d = out_data;
            w.a = out_addr;
            xlog.push_back(w);
         end
         if (frame_done) n_done++;
      end
   end

   task automatic cycle();
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step();
      #2;
      start = 0;
      stop = 0;
   endtask

   task automatic drain(input int n);
      rnd_ready = 0;
      out_ready = 1;
      repeat (n) cycle();
   endtask

   task automatic frame(input int nc, input int nr, input int off, input bit rnd, input int gap_max,
                        input int start_idx, input int stop_idx, input int rst_idx, input int rel_idx);
      int idx;
      idx = 0;
      frame_valid = 1; line_valid = 0; pix_valid = 0;
      cycle();
      cycle();
      for (int r = 0; r < nr; r++) begin
         for (int c = 0; c < nc; c++) begin
            line_valid = 1;
            pix_valid = 1;
            pix_data = rnd ? 10'($urandom) : 10'(off + c + 16 * r);
            if (idx == start_idx) start = 1;
            if (idx == stop_idx) stop = 1;
            if (idx == rst_idx) reset_n = 0;
            if (idx == rel_idx) out_ready = 1;
            cycle();
            reset_n = 1;
            idx++;
            pix_valid = 0;
            repeat ($urandom_range(0, gap_max)) cycle();
         end
         line_valid = 0;
         pix_valid = 0;
         cycle();
         cycle();
      end
      frame_valid = 0;
      cycle();
      cycle();
   endtask

   initial begin : stim
      int d0, nf;
      int e_d[8];
      int e_a[8];
      reset_n = 0; start = 0; continuous = 0; stop = 0;
      frame_valid = 0; line_valid = 0; pix_valid = 0; pix_data = '0; out_ready = 1;
      cycle();
      chk_en = 1;
      cycle();
      check("rst_busy", 32'(busy), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_addr", 32'(out_addr), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_frame_count", 32'(frame_count), 0);
      reset_n = 1;
      cycle();

      // single shot on a 6x3 pattern frame
      xlog.delete(); d0 = n_done;
      start = 1; cycle();
      frame(6, 3, 0, 0, 0, -1, -1, -1, -1);
      drain(8);
`ifndef CAPTURE_DECIMATE_EN
      e_d = '{1, 2, 3, 4, 17, 18, 19, 20};
      check("t1_words", xlog.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < xlog.size()) begin
            check("t1_data", 32'(xlog[i].d), e_d[i]);
            check("t1_addr", 32'(xlog[i].a), i);
         end
`else
      check("t1_words", xlog.size(), 2);
      if (xlog.size() == 2) begin
         check("t1_data0", 32'(xlog[0].d), 1);
         check("t1_data1", 32'(xlog[1].d), 3);
         check("t1_addr1", 32'(xlog[1].a), 1);
      end
`endif
      check("t1_done", n_done - d0, 1);
      check("t1_count", 32'(frame_count), 1);
      check("t1_busy", 32'(busy), 0);

      // start arrives mid-frame: that frame is skipped
      xlog.delete();
      frame(6, 3, 500, 0, 0, 8, -1, -1, -1);
      frame(6, 3, 0, 0, 0, -1, -1, -1, -1);
      drain(8);
      check("t2_nonempty", 32'(xlog.size() != 0), 1);
      if (xlog.size() != 0) begin
         check("t2_first_addr", 32'(xlog[0].a), 0);
         check("t2_first_data", 32'(xlog[0].d), 1);
      end

      // writer stalled: buffer fills, one pixel drops, release at frame pixel 9
`ifndef CAPTURE_DECIMATE_EN
      xlog.delete();
      out_ready = 0;
      start = 1; cycle();
      frame(6, 3, 0, 0, 0, -1, -1, -1, 9);
      drain(8);
      e_d = '{1, 2, 3, 4, 18, 19, 20, 0};
      e_a = '{0, 1, 2, 3, 5, 6, 7, 0};
      check("t3_overflow", 32'(overflow), 1);
      check("t3_words", xlog.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < xlog.size()) begin
            check("t3_data", 32'(xlog[i].d), e_d[i]);
            check("t3_addr", 32'(xlog[i].a), e_a[i]);
         end
`endif

      // continuous over three frames, stop inside the second
      xlog.delete(); d0 = n_done;
      start = 1; continuous = 1; cycle();
      continuous = 0;
      frame(6, 3, 0, 0, 0, -1, -1, -1, -1);
      frame(6, 3, 0, 0, 0, -1, 3, -1, -1);
      frame(6, 3, 0, 0, 0, -1, -1, -1, -1);
      drain(8);
      check("t4_done", n_done - d0, 2);
      check("t4_count", 32'(frame_count), 2);
      check("t4_busy", 32'(busy), 0);
`ifndef CAPTURE_DECIMATE_EN
      check("t4_words", xlog.size(), 16);
`endif

      // short frame: one row of two
      xlog.delete(); d0 = n_done;
      start = 1; cycle();
      frame(6, 1, 0, 0, 0, -1, -1, -1, -1);
      drain(8);
      check("t5_done", n_done - d0, 1);
      check("t5_count", 32'(frame_count), 1);
`ifndef CAPTURE_DECIMATE_EN
      check("t5_words", xlog.size(), 4);
`endif

      // reset mid-frame with a full buffer
      out_ready = 0;
      start = 1; cycle();
      frame(6, 3, 0, 0, 0, -1, -1, 9, -1);
      check("t6_out_valid", 32'(out_valid), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_count", 32'(frame_count), 0);
      drain(4);

      // frame_count wraps: 257 tiny frames
      start = 1; continuous = 1; cycle();
      continuous = 0;
      for (int f = 0; f < 257; f++) frame(1, 1, 0, 0, 0, -1, (f == 256) ? 0 : -1, -1, -1);
      drain(4);
      check("t7_count_wrap", 32'(frame_count), 1);
      check("t7_busy", 32'(busy), 0);

      // randomized traffic
      for (int it = 0; it < 25; it++) begin
         rnd_ready = 1;
         if (it % 4 == 3) begin
            frame(int'($urandom_range(2, 8)), int'($urandom_range(1, 4)), 0, 1, 2,
                  int'($urandom_range(0, 5)), -1, -1, -1);
         end else begin
            start = 1;
            continuous = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) == 0);
            cycle();
            continuous = 0;
         end
         nf = int'($urandom_range(1, 3));
         for (int f = 0; f < nf; f++)
            frame(int'($urandom_range(1, 8)), int'($urandom_range(1, 4)), 0, 1, 2, -1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1, -1, -1);
         stop = 1;
         cycle();
         repeat ($urandom_range(0, 4)) cycle();
      end
      drain(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
